instruction_cache: RTL and testbench
====================================

Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache.
- Answers the fetch stage's PC requests with a 32-bit instruction and a busywait stall signal.
- On a miss, refills a whole 128-bit block from instruction main memory through a read/busywait handshake.
- Sits between the IF stage (upstream initiator) and the instruction memory model (downstream responder).

Parameters:
- NUM_BLOCKS, 8, number of cache lines (power of 2).
- WORDS_PER_BLOCK, 4, 32-bit words per line (fixed at 4 for a 128-bit refill).
- INDEX_W, 3, log2(NUM_BLOCKS).
- TAG_W, 25, 32 - INDEX_W - 4.

Ports:
- CLK  input  1  system clock, all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- PC  input  32  byte address of the requested instruction; word-aligned, bits [1:0] ignored.
- read  input  1  fetch request valid; low when PC = 0xFFFFFFFC (post-reset) or during flush.
- instruction  output  32  instruction word for PC; valid when read=1 and busywait=0.
- busywait  output  1  stall to fetch; the PC register must not advance while high.
- mem_read  output  1  refill request to instruction memory.
- mem_address  output  28  block address (PC[31:4]) of the refill.
- mem_readdata  input  128  refilled block; word0 in [31:0].
- mem_busywait  input  1  memory busy; the block is valid in the first cycle mem_busywait is low after mem_read.

Behaviour:
- Address split: tag = PC[31:7], index = PC[6:4], word offset = PC[3:2].
- Storage per line: valid bit, tag, 128-bit data.
- Hit (combinational): read=1 and state IDLE and valid[index] and tag match.
  - instruction = selected word.
  - busywait = 0.
  - Zero-cycle hit latency; fetch samples on the next posedge.
- Miss in IDLE: busywait = 1 combinationally the same cycle.
  - At the posedge: latch the miss tag and index, then go to MEM_READ.
- FSM states:
  - IDLE: a miss goes to MEM_READ; otherwise stay.
  - MEM_READ: mem_read = 1, mem_address = latched {tag, index}, busywait = 1. Stay while mem_busywait = 1. On a posedge with mem_busywait = 0, write mem_readdata into the latched index, set the tag, set valid = 1, and go to UPDATE.
  - UPDATE: one cycle, busywait = 1, mem_read = 0. Returns to IDLE, where the line now hits.
- Miss latency: detect cycle + N memory cycles + 1 UPDATE + 1 hit cycle.
- When read = 0: busywait = 0, instruction = 32'h0, no state change in IDLE.
- Refill completion: an outstanding refill completes even if read drops or PC changes. The latched address is used, never the live PC.
- Reset values (asynchronous, on RESET high): state = IDLE, all valid = 0, mem_read = 0, mem_address = 0, busywait = 0, instruction = 0.
- Reset mid-refill: mem_read drops immediately; the partially requested line is not written; the line stays invalid.
- Conflict misses: same index with a different tag evicts the line; no write-back is needed (read-only).
- No # delays in RTL; all timing is cycle-based.

Decomposition:
- Shared package icache_pkg holds:
  - Localparams for OFFSET_W = 4, INDEX_W, TAG_W and BLOCK_W = 128.
  - The FSM state encoding (IDLE = 2'd0, MEM_READ = 2'd1, UPDATE = 2'd2).
  - Field-extract functions for tag, index and word.
- One natural sub-module, icache_line_array, contains:
  - The valid, tag and data arrays.
  - One synchronous write port and one asynchronous read port.
  - Async clear of valid on RESET.
- The top level keeps the FSM, hit compare and word mux.

Test Plan:
- Cold miss: reset, then PC=0x00000000 with read=1; memory model holds mem_busywait for 3 cycles. Required response:
  - busywait=1 immediately; mem_read=1 with mem_address=0 until the refill.
  - UPDATE for 1 cycle, then busywait=0 and instruction = word0 of the block.
- Spatial hits: after the cold miss, step PC through 0x4, 0x8, 0xC. Each returns words 1–3 with busywait=0 and no mem_read.
- Conflict: PC=0x00000080 (index 0, tag 1) triggers a refill of line 0. Required response:
  - mem_address = 0x0000008.
  - A subsequent PC=0x0 misses again.
- Reset mid-refill: assert RESET during MEM_READ. Required response:
  - mem_read=0 and busywait=0 within the same cycle.
  - After release, PC=0x0 misses (valid cleared).
- Idle fetch: read=0 with PC=0xFFFFFFFC. Required response: busywait=0, mem_read never asserted, instruction=0.
- PC glitch during refill: change PC to 0x40 while in MEM_READ. Required response:
  - The refill still writes index 0 with tag 0.
  - Then PC=0x40 misses to index 4.

Source files
------------

// File: rtl/instruction_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int NUM_BLOCKS      = 8;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFFSET_W        = 4;
    localparam int INDEX_W         = 3;
    localparam int TAG_W           = 32 - INDEX_W - OFFSET_W;
    localparam int BLOCK_W         = 128;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_e;

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[31 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
        return pc[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [1:0] pc_word(input logic [31:0] pc);
        return pc[3:2];
    endfunction

    function automatic logic [31:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                             input logic [1:0] w);
        return blk[{w, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side bundles of the instruction cache.
interface icache_fetch_if;
    logic [31:0] PC;
    logic        read;
    logic [31:0] instruction;
    logic        busywait;

    modport master (output PC, read, input instruction, busywait);
    modport slave  (input PC, read, output instruction, busywait);
endinterface

interface icache_mem_if;
    import icache_pkg::*;
    logic [TAG_W+INDEX_W-1:0] mem_address;
    logic                     mem_read;
    logic [BLOCK_W-1:0]       mem_readdata;
    logic                     mem_busywait;

    modport master (output mem_read, mem_address,
                    input mem_readdata, mem_busywait);
    modport slave  (input mem_read, mem_address,
                    output mem_readdata, mem_busywait);
endinterface

// File: rtl/instruction_cache_line_array.sv
// Valid/tag/data storage: one synchronous write port, one combinational read port.
module icache_line_array
    import icache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] widx_i,
    input  logic [TAG_W-1:0]   wtag_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    input  logic [INDEX_W-1:0] ridx_i,
    output logic               rvalid_o,
    output logic [TAG_W-1:0]   rtag_o,
    output logic [BLOCK_W-1:0] rdata_o
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: valid gates every use.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with a 128-bit block refill FSM.
module instruction_cache
    import icache_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    icache_fetch_if.slave fetch,
    icache_mem_if.master  mem
);

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [INDEX_W-1:0] miss_idx_q, miss_idx_d;

    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               hit;
    logic               we;
    logic               busy;
    logic               mrd;
    logic [TAG_W+INDEX_W-1:0] maddr;
    logic [31:0]        instr;

    icache_line_array u_lines (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .we_i     (we),
        .widx_i   (miss_idx_q),
        .wtag_i   (miss_tag_q),
        .wdata_i  (mem.mem_readdata),
        .ridx_i   (pc_index(fetch.PC)),
        .rvalid_o (line_valid),
        .rtag_o   (line_tag),
        .rdata_o  (line_data)
    );

    assign hit = fetch.read && (state_q == IDLE) && line_valid
              && (line_tag == pc_tag(fetch.PC));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        busy       = 1'b0;
        mrd        = 1'b0;
        maddr      = '0;
        instr      = 32'h0;
        we         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    instr = word_sel(line_data, pc_word(fetch.PC));
                end else if (fetch.read) begin
                    busy       = 1'b1;
                    miss_tag_d = pc_tag(fetch.PC);
                    miss_idx_d = pc_index(fetch.PC);
                    state_d    = MEM_READ;
                end
            end
            MEM_READ: begin
                busy  = 1'b1;
                mrd   = 1'b1;
                maddr = {miss_tag_q, miss_idx_q};
                if (!mem.mem_busywait) begin
                    we      = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs forced quiet while reset is held, independent of the clock.
    assign fetch.busywait    = busy & ~RESET;
    assign fetch.instruction = RESET ? 32'h0 : instr;
    assign mem.mem_read      = mrd & ~RESET;
    assign mem.mem_address   = RESET ? '0 : maddr;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache with a 3-cycle memory model.
module tb_instruction_cache;

    logic clk;
    logic rst;
    logic [1:0] cnt;
    int total = 0;
    int fails = 0;

    icache_fetch_if fetch ();
    icache_mem_if   mem ();

    instruction_cache dut (
        .CLK   (clk),
        .RESET (rst),
        .fetch (fetch),
        .mem   (mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: busy for 3 cycles after mem_read rises; word = byte addr ^ A5A50000.
    always @(posedge clk) begin
        if (!mem.mem_read) cnt <= 2'd0;
        else if (cnt != 2'd3) cnt <= cnt + 2'd1;
    end
    assign mem.mem_busywait = mem.mem_read && (cnt != 2'd3);
    assign mem.mem_readdata = {{mem.mem_address, 4'hC}, {mem.mem_address, 4'h8},
                               {mem.mem_address, 4'h4}, {mem.mem_address, 4'h0}}
                              ^ {4{32'hA5A5_0000}};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (fetch.busywait !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 40), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        fetch.read = 1'b0;
        fetch.PC = 32'hFFFF_FFFC;
        step();
        step();
        chk("rst_busy", 32'(fetch.busywait), 32'd0);
        chk("rst_mrd", 32'(mem.mem_read), 32'd0);
        chk("rst_maddr", 32'(mem.mem_address), 32'd0);
        chk("rst_instr", fetch.instruction, 32'd0);
        rst = 1'b0;

        // Idle fetch
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_busy", 32'(fetch.busywait), 32'd0);
            chk("idle_mrd", 32'(mem.mem_read), 32'd0);
            chk("idle_instr", fetch.instruction, 32'd0);
        end

        // Cold miss
        fetch.PC = 32'h0;
        fetch.read = 1'b1;
        #1;
        chk("cold_busy0", 32'(fetch.busywait), 32'd1);
        chk("cold_mrd0", 32'(mem.mem_read), 32'd0);
        step();
        chk("cold_mrd1", 32'(mem.mem_read), 32'd1);
        chk("cold_maddr", 32'(mem.mem_address), 32'd0);
        chk("cold_busy1", 32'(fetch.busywait), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cold_mrd_hold", 32'(mem.mem_read), 32'd1);
        end
        step();
        chk("upd_mrd", 32'(mem.mem_read), 32'd0);
        chk("upd_busy", 32'(fetch.busywait), 32'd1);
        step();
        chk("cold_hit_busy", 32'(fetch.busywait), 32'd0);
        chk("cold_hit_instr", fetch.instruction, 32'hA5A5_0000);

        // Spatial hits
        step(); fetch.PC = 32'h4; #1;
        chk("hit4_busy", 32'(fetch.busywait), 32'd0);
        chk("hit4_mrd", 32'(mem.mem_read), 32'd0);
        chk("hit4_instr", fetch.instruction, 32'hA5A5_0004);
        step(); fetch.PC = 32'h8; #1;
        chk("hit8_busy", 32'(fetch.busywait), 32'd0);
        chk("hit8_instr", fetch.instruction, 32'hA5A5_0008);
        step(); fetch.PC = 32'hC; #1;
        chk("hitC_busy", 32'(fetch.busywait), 32'd0);
        chk("hitC_instr", fetch.instruction, 32'hA5A5_000C);

        // Conflict miss on index 0
        step(); fetch.PC = 32'h80; #1;
        chk("conf_busy", 32'(fetch.busywait), 32'd1);
        step();
        chk("conf_mrd", 32'(mem.mem_read), 32'd1);
        chk("conf_maddr", 32'(mem.mem_address), 32'h0000_0008);
        wait_idle("conf_timeout");
        chk("conf_instr", fetch.instruction, 32'hA5A5_0080);
        step(); fetch.PC = 32'h0; #1;
        chk("reconf_busy", 32'(fetch.busywait), 32'd1);
        wait_idle("reconf_timeout");
        chk("reconf_instr", fetch.instruction, 32'hA5A5_0000);

        // PC glitch during refill
        step(); fetch.PC = 32'h80; #1;
        wait_idle("gl_pre_timeout");
        step(); fetch.PC = 32'h0; #1;
        chk("gl_busy", 32'(fetch.busywait), 32'd1);
        step();
        fetch.PC = 32'h40;
        #1;
        chk("gl_maddr", 32'(mem.mem_address), 32'd0);
        begin
            int n = 0;
            while (mem.mem_read === 1'b1 && n < 20) begin
                step();
                n++;
            end
            chk("gl_refill_timeout", 32'(n < 20), 32'd1);
        end
        chk("gl_upd_busy", 32'(fetch.busywait), 32'd1);
        step();
        chk("gl_miss40_busy", 32'(fetch.busywait), 32'd1);
        step();
        chk("gl_miss40_mrd", 32'(mem.mem_read), 32'd1);
        chk("gl_miss40_maddr", 32'(mem.mem_address), 32'h0000_0004);
        wait_idle("gl40_timeout");
        chk("gl40_instr", fetch.instruction, 32'hA5A5_0040);
        step(); fetch.PC = 32'h0; #1;
        chk("gl_idx0_busy", 32'(fetch.busywait), 32'd0);
        chk("gl_idx0_instr", fetch.instruction, 32'hA5A5_0000);

        // Reset mid-refill
        step(); fetch.PC = 32'h80; #1;
        step();
        chk("mr_mrd", 32'(mem.mem_read), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_rst_mrd", 32'(mem.mem_read), 32'd0);
        chk("mr_rst_busy", 32'(fetch.busywait), 32'd0);
        chk("mr_rst_instr", fetch.instruction, 32'd0);
        step();
        step();
        rst = 1'b0;
        fetch.PC = 32'h0;
        #1;
        chk("mr_cleared_busy", 32'(fetch.busywait), 32'd1);
        wait_idle("mr_timeout");
        chk("mr_instr", fetch.instruction, 32'hA5A5_0000);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
